// File: rtl/mux_load_f_h_or_b_seq.sv
// Sequenced load unit: pulse start -> memory read -> wait latency -> extract
// word/half/byte from the low bits and zero/sign-extend into data_out.
// Ports: clk, reset (sync, active-high), start, selector[1:0], sign_ext,
//   addr_in[31:0], mem_addr[31:0], mem_rd, mem_data_in[31:0],
//   data_out[31:0] (registered), done (1-cycle pulse), busy (READ/WAIT).
module mux_load_f_h_or_b_seq #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  selector,
    input  logic        sign_ext,
    input  logic [31:0] addr_in,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_data_in,
    output logic [31:0] data_out,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [1:0]  sel_q;
    logic        sx_q;
    logic        accept;
    logic [31:0] ext;

    // New requests are only taken when no load is in flight.
    assign accept = (state == IDLE) || (state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = READ;
            READ: state_nx = WAIT;
            WAIT: if (cnt == 4'd0) state_nx = DONE;
            DONE: state_nx = start ? READ : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_rd = (state == READ);
        busy   = (state == READ) || (state == WAIT);
        done   = (state == DONE);
    end

    // Extraction uses the latched selector/sign_ext; bit1 of the selector
    // dominates so 2'b10 also means word.
    always_comb begin
        ext = mem_data_in;
        if (sel_q[1])
            ext = mem_data_in;
        else if (sel_q[0])
            ext = {{16{sx_q & mem_data_in[15]}}, mem_data_in[15:0]};
        else
            ext = {{24{sx_q & mem_data_in[7]}}, mem_data_in[7:0]};
    end

    // Datapath: request latch, latency counter, result register.
    // mem_addr is the latched address, so it is held through WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            sel_q    <= '0;
            sx_q     <= 1'b0;
            cnt      <= '0;
            data_out <= '0;
        end else begin
            if (accept && start) begin
                addr_q <= addr_in;
                sel_q  <= selector;
                sx_q   <= sign_ext;
            end
            if (state == READ) cnt <= CNT_INIT;
            if (state == WAIT) begin
                if (cnt == 4'd0) data_out <= ext;
                else             cnt      <= cnt - 4'd1;
            end
        end
    end

    assign mem_addr = addr_q;

endmodule
